// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, one output slot
// and a one-entry skid buffer, with redirect flushing and stale-response discard.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_REQ  | presenting imem_addr=pc (imem_req held low for one cycle after reset)
// ST_WAIT | request accepted, waiting for imem_rvalid (discard drops it)
// ST_HOLD | word parked in skid buffer, slot full and stalled
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        req_q;
  logic        discard;

  logic        accept;
  logic        consume;
  logic        slot_free;

  assign accept    = (state == ST_REQ) && req_q && imem_ready;
  assign consume   = valid_out && !stall;
  assign slot_free = !valid_out || !stall;

  assign imem_req  = req_q;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      discard    <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'h0000_0000;
      instr_out  <= NOP_INSTR;
      pc_out     <= 32'h0000_0000;
      valid_out  <= 1'b0;
    end else begin
      // Default slot behaviour; any load below overrides it.
      if (consume) begin
        valid_out <= 1'b0;
        instr_out <= NOP_INSTR;
      end

      if (redirect) begin
        pc         <= redirect_pc & 32'hFFFF_FFFC;
        valid_out  <= 1'b0;
        instr_out  <= NOP_INSTR;
        skid_instr <= NOP_INSTR;
        skid_pc    <= 32'h0000_0000;
        // A request still in flight must have its response swallowed.
        if (accept || (state == ST_WAIT && !imem_rvalid)) begin
          state   <= ST_WAIT;
          discard <= 1'b1;
          req_q   <= 1'b0;
        end else begin
          state   <= ST_REQ;
          discard <= 1'b0;
          req_q   <= 1'b1;
        end
      end else begin
        case (state)
          ST_REQ: begin
            if (accept) begin
              state <= ST_WAIT;
              req_q <= 1'b0;
            end else begin
              req_q <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid) begin
              if (discard) begin
                discard <= 1'b0;
                state   <= ST_REQ;
                req_q   <= 1'b1;
              end else if (slot_free) begin
                instr_out <= imem_rdata;
                pc_out    <= pc;
                valid_out <= 1'b1;
                pc        <= pc + 32'd4;
                state     <= ST_REQ;
                req_q     <= 1'b1;
              end else begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
                pc         <= pc + 32'd4;
                state      <= ST_HOLD;
                req_q      <= 1'b0;
              end
            end
          end
          ST_HOLD: begin
            if (!stall) begin
              instr_out  <= skid_instr;
              pc_out     <= skid_pc;
              valid_out  <= 1'b1;
              skid_instr <= NOP_INSTR;
              skid_pc    <= 32'h0000_0000;
              state      <= ST_REQ;
              req_q      <= 1'b1;
            end
          end
          default: begin
            state <= ST_REQ;
            req_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
